// File: rtl/mmio_peripheral_bus_pkg.sv
// rtl/mmio_peripheral_bus_pkg.sv - shared constants for the MMIO peripheral bus
package mmio_peripheral_bus_pkg;

   localparam logic [31:0] PERIPH_BASE_DEF = 32'h4000_0000;

   localparam logic [7:0] OFF_TH      = 8'h00;
   localparam logic [7:0] OFF_TL      = 8'h04;
   localparam logic [7:0] OFF_TCON    = 8'h08;
   localparam logic [7:0] OFF_LED     = 8'h0C;
   localparam logic [7:0] OFF_DIGI    = 8'h10;
   localparam logic [7:0] OFF_SYSTICK = 8'h14;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_ST = 2;

   function automatic logic in_window(input logic [31:0] a, input logic [31:0] base);
      return a[31:8] == base[31:8];
   endfunction

endpackage

// File: rtl/mmio_peripheral_bus_timer_core.sv
// rtl/mmio_peripheral_bus_timer_core.sv - reloadable timer (TH/TL/TCON) with level interrupt
module timer_core
   import mmio_peripheral_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wdata,
   input  logic        th_we,
   input  logic        tl_we,
   input  logic        tcon_we,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [2:0]  tcon,
   output logic        irq
);

   logic overflow;
   logic status_set;

   assign overflow   = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
   assign status_set = overflow && tcon[TCON_IE];

   always_ff @(posedge clk) begin
      if (reset) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
      end else begin
         if (th_we)
            th <= wdata;

         // Reload reads the pre-edge TH, so a same-cycle TH write only affects the next reload.
         if (tl_we)
            tl <= wdata;
         else if (tcon[TCON_EN])
            tl <= overflow ? th : tl + 32'd1;

         // Hardware set wins over a software clear so an overflow is never lost.
         if (tcon_we)
            tcon <= {wdata[TCON_ST] | status_set, wdata[TCON_IE], wdata[TCON_EN]};
         else if (status_set)
            tcon[TCON_ST] <= 1'b1;
      end
   end

   assign irq = tcon[TCON_IE] & tcon[TCON_ST];

endmodule

// File: rtl/mmio_peripheral_bus.sv
// rtl/mmio_peripheral_bus.sv - address decode, timer/LED/digit/SysTick registers (MMIO_SYSTICK_EN adds SysTick)
module mmio_peripheral_bus
   import mmio_peripheral_bus_pkg::*;
#(
   parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF,
   parameter int          LED_W       = 8,
   parameter int          DIGI_W      = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       mem_rdata,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   output logic [31:0]       rdata,
   output logic              irq,
   output logic [LED_W-1:0]  leds,
   output logic [DIGI_W-1:0] digi
);

   logic        periph;
   logic [7:0]  offset;
   logic        reg_wr;
   logic [31:0] th;
   logic [31:0] tl;
   logic [2:0]  tcon;
   logic [31:0] systick_val;
   logic [31:0] reg_rdata;
   logic        unused_addr_bits;

   assign periph           = in_window(addr, PERIPH_BASE);
   assign offset           = {addr[7:2], 2'b00};
   assign reg_wr           = mem_write & periph;
   assign mem_rd_o         = mem_read & ~periph;
   assign mem_wr_o         = mem_write & ~periph;
   assign unused_addr_bits = &{1'b0, addr[1:0]};

   timer_core u_timer (
      .clk     (clk),
      .reset   (reset),
      .wdata   (wdata),
      .th_we   (reg_wr && offset == OFF_TH),
      .tl_we   (reg_wr && offset == OFF_TL),
      .tcon_we (reg_wr && offset == OFF_TCON),
      .th      (th),
      .tl      (tl),
      .tcon    (tcon),
      .irq     (irq)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         leds <= '0;
         digi <= '0;
      end else begin
         if (reg_wr && offset == OFF_LED)
            leds <= wdata[LED_W-1:0];
         if (reg_wr && offset == OFF_DIGI)
            digi <= wdata[DIGI_W-1:0];
      end
   end

`ifdef MMIO_SYSTICK_EN
   logic [31:0] systick;

   always_ff @(posedge clk) begin
      if (reset)
         systick <= '0;
      else
         systick <= systick + 32'd1;
   end

   assign systick_val = systick;
`else
   assign systick_val = '0;
`endif

   always_comb begin
      reg_rdata = '0;
      case (offset)
         OFF_TH:      reg_rdata = th;
         OFF_TL:      reg_rdata = tl;
         OFF_TCON:    reg_rdata[2:0] = tcon;
         OFF_LED:     reg_rdata[LED_W-1:0] = leds;
         OFF_DIGI:    reg_rdata[DIGI_W-1:0] = digi;
         OFF_SYSTICK: reg_rdata = systick_val;
         default:     reg_rdata = '0;
      endcase
   end

   assign rdata = periph ? reg_rdata : mem_rdata;

endmodule

// File: tb/tb_mmio_peripheral_bus.sv
// tb/tb_mmio_peripheral_bus.sv - self-checking bench for mmio_peripheral_bus with a behavioural model
module tb_mmio_peripheral_bus;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata, mem_rdata, rdata;
   logic        mem_read, mem_write, mem_rd_o, mem_wr_o, irq;
   logic [7:0]  leds;
   logic [11:0] digi;

   int errors = 0;
   int checks = 0;

   // Behavioural model of the peripheral register state
   logic [31:0] m_th, m_tl, m_st;
   logic [2:0]  m_tcon;
   logic [7:0]  m_leds;
   logic [11:0] m_digi;

   always #5 clk = ~clk;

   mmio_peripheral_bus dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata),
      .mem_rd_o  (mem_rd_o),
      .mem_wr_o  (mem_wr_o),
      .rdata     (rdata),
      .irq       (irq),
      .leds      (leds),
      .digi      (digi)
   );

   function automatic logic is_periph(input logic [31:0] a);
      return a[31:8] == 24'h40_0000;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] md);
      if (!is_periph(a))
         return md;
      case (a[7:0] & 8'hFC)
         8'h00: return m_th;
         8'h04: return m_tl;
         8'h08: return {29'd0, m_tcon};
         8'h0C: return {24'd0, m_leds};
         8'h10: return {20'd0, m_digi};
`ifdef MMIO_SYSTICK_EN
         8'h14: return m_st;
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_update(input logic r, input logic [31:0] a, input logic [31:0] d, input logic w);
      logic        ovf, hw_set;
      logic [31:0] n_tl;
      logic [2:0]  n_tcon;
      if (r) begin
         m_th = 0; m_tl = 0; m_tcon = 0; m_leds = 0; m_digi = 0; m_st = 0;
         return;
      end
      m_st   = m_st + 1;
      ovf    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
      hw_set = ovf && m_tcon[1];
      n_tl   = !m_tcon[0] ? m_tl : (ovf ? m_th : m_tl + 1);
      n_tcon = m_tcon | (hw_set ? 3'b100 : 3'b000);
      if (w && is_periph(a)) begin
         case (a[7:0] & 8'hFC)
            8'h00: m_th = d;
            8'h04: n_tl = d;
            8'h08: n_tcon = {d[2] | hw_set, d[1:0]};
            8'h0C: m_leds = d[7:0];
            8'h10: m_digi = d[11:0];
            default: ;
         endcase
      end
      m_tl   = n_tl;
      m_tcon = n_tcon;
   endtask

   task automatic tick();
      logic        r, w;
      logic [31:0] a, d;
      r = reset; w = mem_write; a = addr; d = wdata;
      @(posedge clk);
      #1;
      model_update(r, a, d, w);
   endtask

   task automatic poke(input logic [7:0] off, input logic [31:0] d);
      addr = 32'h4000_0000 | {24'd0, off};
      wdata = d;
      mem_write = 1'b1;
      mem_read = 1'b0;
      tick();
      mem_write = 1'b0;
   endtask

   task automatic peek(input logic [7:0] off, output logic [31:0] v);
      addr = 32'h4000_0000 | {24'd0, off};
      mem_read = 1'b1;
      mem_write = 1'b0;
      #1;
      v = rdata;
      mem_read = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b1; addr = 32'h10; mem_read = 1'b1; mem_write = 1'b0;
      wdata = 0; mem_rdata = 32'h1234_5678;
      tick();
      tick();
      checks++;
      if (mem_rd_o !== 1'b1 || rdata !== 32'h1234_5678) begin
         errors++;
         $display("FAIL reset_passthru: mem_rd_o=%b rdata=%h required 1 / 12345678", mem_rd_o, rdata);
      end
      reset = 1'b0;
      mem_read = 1'b0;
      for (int i = 0; i < 5; i++) begin
         peek(8'(i * 4), v);
         checks++;
         if (v !== 32'd0) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h required 0", i, v);
         end
      end
      checks++;
      if (irq !== 1'b0 || leds !== 8'd0 || digi !== 12'd0) begin
         errors++;
         $display("FAIL reset_outs: irq=%b leds=%h digi=%h required 0", irq, leds, digi);
      end
   endtask

   task automatic test_passthrough();
      addr = 32'h0000_0010; mem_rdata = 32'hDEAD_BEEF; mem_read = 1'b1; mem_write = 1'b0;
      #1;
      checks++;
      if (rdata !== 32'hDEAD_BEEF || mem_rd_o !== 1'b1) begin
         errors++;
         $display("FAIL passthru_read: rdata=%h mem_rd_o=%b required deadbeef / 1", rdata, mem_rd_o);
      end
      mem_read = 1'b0;
      addr = 32'h4000_000C; wdata = 32'h5A; mem_write = 1'b1;
      #1;
      checks++;
      if (mem_wr_o !== 1'b0) begin
         errors++;
         $display("FAIL passthru_wr_gate: mem_wr_o=%b required 0", mem_wr_o);
      end
      tick();
      mem_write = 1'b0;
      checks++;
      if (leds !== 8'h5A) begin
         errors++;
         $display("FAIL passthru_led: leds=%h required 5a", leds);
      end
   endtask

   task automatic test_reload();
      logic [31:0] v;
      poke(8'h00, 32'hFFFF_FFFC);
      poke(8'h04, 32'hFFFF_FFFE);
      poke(8'h08, 32'h3);
      tick();
      peek(8'h04, v);
      checks++;
      if (v !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL reload_pre: TL=%h required ffffffff", v);
      end
      tick();
      peek(8'h04, v);
      checks++;
      if (v !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL reload_tl: TL=%h required fffffffc", v);
      end
      peek(8'h08, v);
      checks++;
      if (v !== 32'h7 || irq !== 1'b1) begin
         errors++;
         $display("FAIL reload_tcon: TCON=%h irq=%b required 7 / 1", v, irq);
      end
   endtask

   task automatic test_collision();
      logic [31:0] v;
      tick(); tick(); tick();
      poke(8'h08, 32'h3);
      peek(8'h08, v);
      checks++;
      if (v !== 32'h7 || irq !== 1'b1) begin
         errors++;
         $display("FAIL collide_tcon: TCON=%h irq=%b required 7 / 1", v, irq);
      end
      tick(); tick(); tick();
      poke(8'h04, 32'h5);
      peek(8'h04, v);
      checks++;
      if (v !== 32'h5) begin
         errors++;
         $display("FAIL collide_tl: TL=%h required 5", v);
      end
      poke(8'h04, 32'hFFFF_FFFF);
      poke(8'h00, 32'h100);
      peek(8'h04, v);
      checks++;
      if (v !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL collide_th_tl: TL=%h required fffffffc", v);
      end
      peek(8'h00, v);
      checks++;
      if (v !== 32'h100) begin
         errors++;
         $display("FAIL collide_th: TH=%h required 100", v);
      end
      poke(8'h08, 32'h0);
   endtask

   task automatic test_regs();
      logic [31:0] v;
      poke(8'h0C, 32'hFFFF_FFA5);
      poke(8'h10, 32'h7F3);
      peek(8'h0C, v);
      checks++;
      if (v !== 32'hA5) begin
         errors++;
         $display("FAIL regs_led: got %h required a5", v);
      end
      peek(8'h10, v);
      checks++;
      if (v !== 32'h7F3 || digi !== 12'h7F3) begin
         errors++;
         $display("FAIL regs_digi: got %h port %h required 7f3", v, digi);
      end
      peek(8'h18, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL regs_unmapped: got %h required 0", v);
      end
      poke(8'h14, 32'hCAFE_0000);
      peek(8'h14, v);
      checks++;
      if (v !== model_read(32'h4000_0014, 32'h0) || v === 32'hCAFE_0000) begin
         errors++;
         $display("FAIL regs_systick_wr: got %h required %h", v, model_read(32'h4000_0014, 32'h0));
      end
   endtask

   task automatic test_systick();
      logic [31:0] v1, v2;
      peek(8'h14, v1);
      for (int i = 0; i < 10; i++) tick();
      peek(8'h14, v2);
      checks++;
`ifdef MMIO_SYSTICK_EN
      if (v2 - v1 !== 32'd10 || v2 !== m_st) begin
         errors++;
         $display("FAIL systick_delta: got %h and %h required difference 10 ending at %h", v1, v2, m_st);
      end
`else
      if (v1 !== 32'd0 || v2 !== 32'd0) begin
         errors++;
         $display("FAIL systick_off: got %h and %h required 0", v1, v2);
      end
`endif
   endtask

   task automatic test_random();
      logic [7:0]  offs [7];
      logic [7:0]  off;
      int          op;
      offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 9);
         mem_rdata = $urandom;
         if (op < 2) begin
            addr = $urandom & 32'h3FFF_FFFF;
            mem_read = 1'($urandom_range(0, 1));
            mem_write = 1'($urandom_range(0, 1));
            wdata = $urandom;
         end else if (op == 2) begin
            addr = 32'h4000_0100 | ($urandom & 32'hFF);
            mem_read = 1'b1;
            mem_write = 1'($urandom_range(0, 1));
            wdata = $urandom;
         end else begin
            off = offs[$urandom_range(0, 6)];
            addr = 32'h4000_0000 | {24'd0, off} | 32'($urandom_range(0, 3));
            mem_read = 1'b1;
            mem_write = ($urandom_range(0, 3) == 0);
            wdata = (off == 8'h04) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         end
         #1;
         checks++;
         if (rdata !== model_read(addr, mem_rdata)) begin
            errors++;
            $display("FAIL rand_rdata[%0d]: addr=%h got %h required %h", i, addr, rdata, model_read(addr, mem_rdata));
         end
         checks++;
         if (mem_rd_o !== (mem_read && !is_periph(addr)) || mem_wr_o !== (mem_write && !is_periph(addr))) begin
            errors++;
            $display("FAIL rand_strobe[%0d]: rd=%b wr=%b addr=%h", i, mem_rd_o, mem_wr_o, addr);
         end
         checks++;
         if (irq !== (m_tcon[1] & m_tcon[2]) || leds !== m_leds || digi !== m_digi) begin
            errors++;
            $display("FAIL rand_outs[%0d]: irq=%b leds=%h digi=%h required %b %h %h",
                     i, irq, leds, digi, m_tcon[1] & m_tcon[2], m_leds, m_digi);
         end
         tick();
      end
      mem_read = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      poke(8'h00, 32'h0);
      poke(8'h04, 32'h10);
      poke(8'h08, 32'h7);
      poke(8'h0C, 32'hFF);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      peek(8'h04, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL resetmid_tl: TL=%h required 0", v);
      end
      peek(8'h08, v);
      checks++;
      if (v !== 32'h0 || irq !== 1'b0 || leds !== 8'h0) begin
         errors++;
         $display("FAIL resetmid_state: TCON=%h irq=%b leds=%h required 0", v, irq, leds);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_reload();
      test_collision();
      test_regs();
      test_systick();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
